// File: rtl/half_band_decim.sv
// half_band_decim: half-band FIR decimate-by-2 with folded symmetric taps and a serial MAC.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-low reset
//   clk_en     clock enable; low freezes every register and gates both handshakes
//   in_data    signed input sample (DATA_W)
//   in_valid   input sample valid
//   in_ready   block accepts in_data this cycle
//   out_data   signed decimated output (DATA_W)
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//
// Build option: define HBD_SATURATE_EN to clamp the rounded result to the DATA_W range;
// otherwise the result wraps (two's complement) and no clamp logic is built.
module half_band_decim #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int NUQ = 3,
    parameter logic [NUQ*COEF_W-1:0] COEF_VEC = {18'sd1638, -18'sd9830, 18'sd40960}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int N_TAPS = 4 * NUQ - 1;
    localparam int C = 2 * NUQ - 1;
    localparam int ACC_W = DATA_W + COEF_W + 2 + $clog2(NUQ);
    localparam int STEP_W = $clog2(NUQ + 1);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (COEF_W - 2);

    typedef enum logic [2:0] {S_IN0, S_IN1, S_MAC, S_RND, S_OUT} state_t;

    state_t                          state, state_nx;
    logic        [STEP_W-1:0]        step;
    logic signed [DATA_W-1:0]        h [N_TAPS];
    logic signed [ACC_W-1:0]         acc;
    logic signed [ACC_W-1:0]         sum;
    logic signed [DATA_W:0]          pre;
    logic signed [COEF_W-1:0]        coef;
    logic signed [DATA_W+COEF_W:0]   prod;
    logic signed [DATA_W-1:0]        nar;

    // Step s (1..NUQ) folds the tap pair that shares coefficient s-1.
    always_comb begin
        pre = '0;
        coef = '0;
        for (int j = 0; j < NUQ; j++) begin
            if (step == STEP_W'(j + 1)) begin
                pre = {h[C-1-2*j][DATA_W-1], h[C-1-2*j]} + {h[C+1+2*j][DATA_W-1], h[C+1+2*j]};
                coef = COEF_VEC[j*COEF_W +: COEF_W];
            end
        end
    end

    assign prod = pre * coef;
    assign sum = acc + HALF;

`ifdef HBD_SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
    logic signed [ACC_W-1:0] rnd;
    assign rnd = sum >>> (COEF_W - 1);
    assign nar = rnd > MAXV ? {1'b0, {(DATA_W-1){1'b1}}} :
                 rnd < MINV ? {1'b1, {(DATA_W-1){1'b0}}} : rnd[DATA_W-1:0];
`else
    assign nar = DATA_W'(sum >>> (COEF_W - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IN0;
            step <= '0;
            acc <= '0;
            out_data <= '0;
            for (int k = 0; k < N_TAPS; k++) h[k] <= '0;
        end else if (clk_en) begin
            state <= state_nx;
            if (in_valid && in_ready) begin
                h[0] <= in_data;
                for (int k = 1; k < N_TAPS; k++) h[k] <= h[k-1];
            end
            step <= state == S_MAC ? step + 1'b1 : '0;
            // Centre tap of 0.5 is a shift: aligned one bit below the Q1.(COEF_W-1) products.
            if (state == S_MAC) acc <= step == '0 ? ACC_W'(h[C]) <<< (COEF_W - 2) : acc + ACC_W'(prod);
            if (state == S_RND) out_data <= nar;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IN0: state_nx = in_valid ? S_IN1 : S_IN0;
            S_IN1: state_nx = in_valid ? S_MAC : S_IN1;
            S_MAC: state_nx = step == STEP_W'(NUQ) ? S_RND : S_MAC;
            S_RND: state_nx = S_OUT;
            S_OUT: state_nx = out_ready ? S_IN0 : S_OUT;
            default: state_nx = S_IN0;
        endcase
    end

    always_comb begin
        in_ready = clk_en && (state == S_IN0 || state == S_IN1);
        out_valid = clk_en && state == S_OUT;
    end
endmodule
